// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shift op and sequencer state encodings shared by the shift unit
package alu_shift_pkg;
  typedef enum logic [1:0] {SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROL} shift_op_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit combinational shift of work by op; nxt is the shifted word, bit_out the bit leaving
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] work,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] nxt,
  output logic             bit_out
);
  always_comb begin
    nxt = op == SHIFT_LSL ? {work[WIDTH-2:0], 1'b0} :
          op == SHIFT_LSR ? {1'b0, work[WIDTH-1:1]} :
          op == SHIFT_ASR ? {work[WIDTH-1], work[WIDTH-1:1]} :
                            {work[WIDTH-2:0], work[WIDTH-1]};
    bit_out = (op == SHIFT_LSL || op == SHIFT_ROL) ? work[WIDTH-1] : work[0];
  end
endmodule

// File: rtl/iterative_shift_unit.sv
// iterative_shift_unit: start/busy/done sequencer shifting a by amt one bit per clock; outputs y, carry, zero
module iterative_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);
  state_t           state;
  shift_op_t        op_r;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nxt;
  logic [AMT_W-1:0] cnt;
  logic             c_int;
  logic             bit_out;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .work    (work),
    .op      (op_r),
    .nxt     (nxt),
    .bit_out (bit_out)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_r  <= SHIFT_LSL;
      work  <= '0;
      cnt   <= '0;
      c_int <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          work  <= a;
          cnt   <= amt;
          op_r  <= shift_op_t'(op);
          c_int <= 1'b0;
          busy  <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: if (cnt != '0) begin
          work  <= nxt;
          c_int <= bit_out;
          cnt   <= cnt - 1'b1;
        end else begin
          y     <= work;
          carry <= c_int;
          zero  <= work == '0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_shift_unit.sv
// tb_iterative_shift_unit: directed and random checks of iterative_shift_unit against an arithmetic shift model
module tb_iterative_shift_unit;
  localparam int W  = 4;
  localparam int AW = 3;
  logic          clk, reset, start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [AW-1:0] amt;
  logic          busy, done, carry, zero;
  logic [W-1:0]  y;
  int n_chk = 0;
  int n_fail = 0;
  iterative_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .carry (carry),
    .zero  (zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [AW-1:0] m,
                       output logic [W-1:0] ey, output logic ec);
    logic [63:0] u, t;
    logic signed [63:0] s;
    int r;
    u = 64'(av);
    s = {{(64-W){av[W-1]}}, av};
    r = int'(m) % W;
    ec = 1'b0;
    case (o)
      2'd0: begin t = u << m; ey = t[W-1:0]; if (m != 0) ec = t[W]; end
      2'd1: begin t = u >> m; ey = t[W-1:0]; if (m != 0) ec = u[m-1]; end
      2'd2: begin t = s >>> m; ey = t[W-1:0]; if (m != 0) ec = s[m-1]; end
      default: begin t = (u << r) | (u >> (W - r)); ey = t[W-1:0]; if (m != 0) ec = ey[0]; end
    endcase
  endtask
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] av, input logic [AW-1:0] m,
                       input bit hold, input logic [W-1:0] ey, input logic ec);
    int n;
    logic [W-1:0] yp;
    yp = y;
    start = 1'b1; op = o; a = av; amt = m;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    op = 2'($urandom); a = W'($urandom); amt = AW'($urandom);
    check("busy_accept", 32'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      check("y_held", 32'(y), 32'(yp));
      check("busy_shift", 32'(busy), 1);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, int'(m) + 1);
    check("y", 32'(y), 32'(ey));
    check("carry", 32'(carry), 32'(ec));
    check("zero", 32'(zero), 32'(ey == '0));
    check("busy_done", 32'(busy), 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask
  initial begin
    logic [1:0] o;
    logic [W-1:0] av, ey;
    logic [AW-1:0] m;
    logic ec;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; amt = '0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_carry", 32'(carry), 0);
    check("rst_zero", 32'(zero), 1);
    @(negedge clk); reset = 1'b0;
    do_op(2'd0, 4'b0001, 3'd1, 1'b0, 4'b0010, 1'b0);
    do_op(2'd0, 4'b1000, 3'd1, 1'b0, 4'b0000, 1'b1);
    do_op(2'd0, 4'b0011, 3'd5, 1'b0, 4'b0000, 1'b0);
    do_op(2'd2, 4'b1000, 3'd2, 1'b0, 4'b1110, 1'b0);
    do_op(2'd1, 4'b1011, 3'd1, 1'b0, 4'b0101, 1'b1);
    do_op(2'd3, 4'b1001, 3'd3, 1'b0, 4'b1100, 1'b0);
    do_op(2'd3, 4'b0110, 3'd4, 1'b0, 4'b0110, 1'b0);
    do_op(2'd1, 4'b0101, 3'd0, 1'b1, 4'b0101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ignored_start_done", 32'(done), 0);
      check("ignored_start_busy", 32'(busy), 0);
      check("ignored_start_y", 32'(y), 32'(4'b0101));
    end
    start = 1'b1; op = 2'd0; a = 4'b0001; amt = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_y", 32'(y), 0);
    check("abort_carry", 32'(carry), 0);
    check("abort_zero", 32'(zero), 1);
    @(negedge clk); reset = 1'b0;
    do_op(2'd0, 4'b0010, 3'd1, 1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      av = W'($urandom);
      m = AW'($urandom);
      model(o, av, m, ey, ec);
      do_op(o, av, m, 1'b0, ey, ec);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
